// File: rtl/execute_if.sv
// Decode-to-execute-to-memory bundle: instruction operands and control from
// decode, the stall back to decode, and the registered memory-stage outputs.
interface execute_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [3:0]      alu_op;
    logic            mem_en;
    logic            mem_write;
    logic            load_unsigned;
    logic [1:0]      size;
    logic            en_wb;
    logic            use_pcp4;
    logic [XLEN-1:0] pcp4;
    logic [4:0]      reg_write;

    logic            busy;
    logic [XLEN-1:0] result_out;
    logic [XLEN-1:0] write_data_out;
    logic            mem_en_out;
    logic            write_out;
    logic            load_unsigned_out;
    logic [1:0]      size_out;
    logic            en_wb_out;
    logic            use_pcp4_out;
    logic [XLEN-1:0] pcp4_out;
    logic [4:0]      reg_write_out;

    modport master (
        output in_valid, rs1, rs2, imm, use_imm, alu_op, mem_en, mem_write,
               load_unsigned, size, en_wb, use_pcp4, pcp4, reg_write,
        input  busy, result_out, write_data_out, mem_en_out, write_out,
               load_unsigned_out, size_out, en_wb_out, use_pcp4_out, pcp4_out,
               reg_write_out
    );

    modport slave (
        input  in_valid, rs1, rs2, imm, use_imm, alu_op, mem_en, mem_write,
               load_unsigned, size, en_wb, use_pcp4, pcp4, reg_write,
        output busy, result_out, write_data_out, mem_en_out, write_out,
               load_unsigned_out, size_out, en_wb_out, use_pcp4_out, pcp4_out,
               reg_write_out
    );
endinterface

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus a 32-step iterative unsigned
// multiplier / restoring divider, registering results into the memory stage.
module execute #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    execute_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e          state, state_next;
    logic [4:0]      cnt;
    alu_op_e         op;
    logic [XLEN-1:0] op_a, op_b, alu_result, long_result;
    logic            is_mul, is_div, last_step, load_valid;

    logic [2*XLEN-1:0] product, product_next, mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   quotient, quotient_next, divisor, remainder, remainder_next;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;

    assign op        = alu_op_e'(bus.alu_op);
    assign op_a      = bus.rs1;
    assign op_b      = bus.use_imm ? bus.imm : bus.rs2;
    assign is_mul    = (op == OP_MUL) || (op == OP_MULHU);
    assign is_div    = (op == OP_DIVU) || (op == OP_REMU);
    assign last_step = (state != S_IDLE) && (cnt == 5'd31);

    // Gated by rst_n so decode sees no stall while the stage is held in reset.
    assign bus.busy = rst_n &&
                      (((state == S_IDLE) && bus.in_valid && (is_mul || is_div)) ||
                       ((state != S_IDLE) && (cnt != 5'd31)));

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SLL:  alu_result = op_a << op_b[4:0];
            OP_SRL:  alu_result = op_a >> op_b[4:0];
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_result = '0;
        endcase
    end

    // One shift-add step and one restoring-division step, used both to update
    // the iteration registers and to deliver the answer on the final edge.
    assign product_next   = mplier[0] ? product + mcand : product;
    assign rem_shift      = {remainder, quotient[XLEN-1]};
    assign rem_ge         = rem_shift >= {1'b0, divisor};
    assign remainder_next = rem_ge ? rem_shift[XLEN-1:0] - divisor : rem_shift[XLEN-1:0];
    assign quotient_next  = {quotient[XLEN-2:0], rem_ge};

    always_comb begin
        case (op)
            OP_MULHU: long_result = product_next[2*XLEN-1:XLEN];
            OP_DIVU:  long_result = quotient_next;
            OP_REMU:  long_result = remainder_next;
            default:  long_result = product_next[XLEN-1:0];
        endcase
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        load_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid && is_mul)      state_next = S_MUL;
                else if (bus.in_valid && is_div) state_next = S_DIV;
                else                             load_valid = bus.in_valid;
            end
            S_MUL, S_DIV: begin
                if (last_step) begin
                    state_next = S_IDLE;
                    load_valid = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == S_IDLE) ? 5'd0 : cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            quotient  <= '0;
            divisor   <= '0;
            remainder <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && is_mul) begin
                        product <= '0;
                        mcand   <= {{XLEN{1'b0}}, op_a};
                        mplier  <= op_b;
                    end
                    if (bus.in_valid && is_div) begin
                        quotient  <= op_a;
                        divisor   <= op_b;
                        remainder <= '0;
                    end
                end
                S_MUL: begin
                    product <= product_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                end
                S_DIV: begin
                    quotient  <= quotient_next;
                    remainder <= remainder_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result_out        <= '0;
            bus.write_data_out    <= '0;
            bus.mem_en_out        <= 1'b0;
            bus.write_out         <= 1'b0;
            bus.load_unsigned_out <= 1'b0;
            bus.size_out          <= '0;
            bus.en_wb_out         <= 1'b0;
            bus.use_pcp4_out      <= 1'b0;
            bus.pcp4_out          <= '0;
            bus.reg_write_out     <= '0;
        end else begin
            bus.result_out        <= (state == S_IDLE) ? alu_result : long_result;
            bus.write_data_out    <= bus.rs2;
            bus.mem_en_out        <= load_valid && bus.mem_en;
            bus.write_out         <= bus.mem_write;
            bus.load_unsigned_out <= bus.load_unsigned;
            bus.size_out          <= bus.size;
            bus.en_wb_out         <= load_valid && bus.en_wb;
            bus.use_pcp4_out      <= bus.use_pcp4;
            bus.pcp4_out          <= bus.pcp4;
            bus.reg_write_out     <= bus.reg_write;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: ALU ops, iterative mul/div latency,
// pipelined issue honouring busy, bubbles/illegal ops and async reset.
module tb_execute;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                           XOR_ = 4'd4, SLL = 4'd5, SRL = 4'd6, SRA = 4'd7,
                           SLT = 4'd8, SLTU = 4'd9, MUL = 4'd10, MULHU = 4'd11,
                           DIVU = 4'd12, REMU = 4'd13;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    execute_if #(.XLEN(32)) bus ();
    execute #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_imm;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t alu_vecs[12] = '{
        '{ADD,  32'h0000_0010, 32'hFFFF_FFFC, 1'b1, 32'h0000_000C},
        '{SUB,  32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE},
        '{AND_, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_F000},
        '{OR_,  32'h0000_F0F0, 32'h0000_0F0F, 1'b0, 32'h0000_FFFF},
        '{XOR_, 32'h0000_FF00, 32'h0000_0FF0, 1'b1, 32'h0000_F0F0},
        '{SLL,  32'h0000_0001, 32'h0000_001F, 1'b1, 32'h8000_0000},
        '{SLL,  32'h0000_0003, 32'h0000_0021, 1'b0, 32'h0000_0006},
        '{SRL,  32'h8000_0000, 32'h0000_0004, 1'b0, 32'h0800_0000},
        '{SRA,  32'h8000_0000, 32'h0000_0004, 1'b1, 32'hF800_0000},
        '{SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001},
        '{SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000},
        '{ADD,  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.rs1           = '0;
        bus.rs2           = '0;
        bus.imm           = '0;
        bus.use_imm       = 1'b0;
        bus.alu_op        = ADD;
        bus.mem_en        = 1'b0;
        bus.mem_write     = 1'b0;
        bus.load_unsigned = 1'b0;
        bus.size          = 2'd0;
        bus.en_wb         = 1'b0;
        bus.use_pcp4      = 1'b0;
        bus.pcp4          = '0;
        bus.reg_write     = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic use_imm, input logic mem_en,
                         input logic wr, input logic en_wb, input logic [4:0] rw);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.rs1       = a;
        bus.rs2       = rs2;
        bus.imm       = imm;
        bus.use_imm   = use_imm;
        bus.mem_en    = mem_en;
        bus.mem_write = wr;
        bus.en_wb     = en_wb;
        bus.reg_write = rw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #3;
        vectors++;
        if (bus.result_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected %h", bus.result_out, 32'h0);
        end
        vectors++;
        if ({bus.mem_en_out, bus.en_wb_out, bus.write_out, bus.reg_write_out} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b%b%b %h expected all zero",
                     bus.mem_en_out, bus.en_wb_out, bus.write_out, bus.reg_write_out);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        // Store-style ADD: address from rs1+imm, store data is rs2 not imm.
        issue(ADD, 32'h10, 32'hAB, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5);
        tick();
        vectors++;
        if ({bus.result_out, bus.write_data_out} !== {32'h0C, 32'hAB}) begin
            miscompares++;
            $display("FAIL add_store: got res %h wdata %h expected res 0000000c wdata 000000ab",
                     bus.result_out, bus.write_data_out);
        end
        vectors++;
        if ({bus.write_out, bus.mem_en_out, bus.en_wb_out, bus.reg_write_out} !== {3'b111, 5'd5}) begin
            miscompares++;
            $display("FAIL add_ctrl: got w%b m%b wb%b rd%0d expected w1 m1 wb1 rd5",
                     bus.write_out, bus.mem_en_out, bus.en_wb_out, bus.reg_write_out);
        end
        // Back-to-back single-cycle ops, one result per edge.
        for (int i = 0; i < 12; i++) begin
            issue(alu_vecs[i].op, alu_vecs[i].a,
                  alu_vecs[i].use_imm ? 32'h0000_00AB : alu_vecs[i].b,
                  alu_vecs[i].use_imm ? alu_vecs[i].b : 32'hDEAD_BEEF,
                  alu_vecs[i].use_imm, 1'b0, 1'b0, 1'b1, 5'(i));
            tick();
            vectors++;
            if (bus.result_out !== alu_vecs[i].exp || bus.en_wb_out !== 1'b1) begin
                miscompares++;
                $display("FAIL alu_vec%0d op%0d: got %h wb%b expected %h wb1",
                         i, alu_vecs[i].op, bus.result_out, bus.en_wb_out, alu_vecs[i].exp);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic run_long(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int busy_cycles = 0;
        int valid_count = 0;
        logic [31:0] res = '0;
        logic [4:0] rd = '0;
        issue(op, a, b, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17);
        for (int k = 0; k <= 32; k++) begin
            #1;
            if (bus.busy === 1'b1) busy_cycles++;
            tick();
            if (bus.en_wb_out === 1'b1) begin
                valid_count++;
                res = bus.result_out;
                rd  = bus.reg_write_out;
                if (k != 32) $display("FAIL %s_early: output valid at edge E%0d expected only at E32", name, k);
            end
        end
        drive_idle();
        vectors++;
        if (valid_count !== 1 || res !== exp || rd !== 5'd17) begin
            miscompares++;
            $display("FAIL %s: got %0d outputs res %h rd %0d expected 1 output res %h rd 17",
                     name, valid_count, res, rd, exp);
        end
        vectors++;
        if (busy_cycles !== 32) begin
            miscompares++;
            $display("FAIL %s_busy: got %0d busy cycles expected 32", name, busy_cycles);
        end
        tick();
    endtask

    task automatic test_muldiv();
        run_long("mul",       MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_long("mulhu",     MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_long("mul_small", MUL,   32'd1234,      32'd5678,      32'd7006652);
        run_long("divu",      DIVU,  32'd100,       32'd7,         32'd14);
        run_long("remu",      REMU,  32'd100,       32'd7,         32'd2);
        run_long("divu_zero", DIVU,  32'h1234,      32'h0,         32'hFFFF_FFFF);
        run_long("remu_zero", REMU,  32'h1234,      32'h0,         32'h1234);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[3]  = '{ADD, MUL, ADD};
        logic [31:0] as[3]   = '{32'd1, 32'd3, 32'd10};
        logic [31:0] bs[3]   = '{32'd2, 32'd5, 32'd20};
        int          exp_cyc[3] = '{1, 34, 35};
        logic [31:0] exp_res[3] = '{32'd3, 32'd15, 32'd30};
        int          got_cyc[3] = '{0, 0, 0};
        logic [31:0] got_res[3] = '{32'h0, 32'h0, 32'h0};
        int          idx = 0;
        int          nvalid = 0;
        logic        stalled;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (idx < 3) issue(ops[idx], as[idx], bs[idx], 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(idx + 1));
            else drive_idle();
            #1;
            stalled = bus.busy;
            tick();
            if (bus.en_wb_out === 1'b1) begin
                if (nvalid < 3) begin
                    got_cyc[nvalid] = cyc;
                    got_res[nvalid] = bus.result_out;
                end
                nvalid++;
            end
            if (!stalled && idx < 3) idx++;
        end
        vectors++;
        if (nvalid !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d outputs expected 3", nvalid);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got_cyc[i] !== exp_cyc[i] || got_res[i] !== exp_res[i]) begin
                miscompares++;
                $display("FAIL b2b_out%0d: got cycle %0d res %h expected cycle %0d res %h",
                         i, got_cyc[i], got_res[i], exp_cyc[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_bubble_illegal();
        issue(ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9);
        bus.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus.mem_en_out !== 1'b0 || bus.en_wb_out !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble: got mem_en %b en_wb %b expected 0 0", bus.mem_en_out, bus.en_wb_out);
        end
        issue(4'd15, 32'd5, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        tick();
        vectors++;
        if (bus.result_out !== 32'h0 || bus.en_wb_out !== 1'b1 || bus.reg_write_out !== 5'd4) begin
            miscompares++;
            $display("FAIL illegal_op: got res %h wb %b rd %0d expected 00000000 1 4",
                     bus.result_out, bus.en_wb_out, bus.reg_write_out);
        end
        issue(4'd14, 32'd5, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_busy: got %b expected 0", bus.busy);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_div();
        int stray = 0;
        issue(DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3);
        tick();
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.result_out, bus.write_data_out} !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_mid_data: got res %h wdata %h expected 0 0", bus.result_out, bus.write_data_out);
        end
        vectors++;
        if ({bus.mem_en_out, bus.write_out, bus.en_wb_out, bus.reg_write_out, bus.busy} !== 9'h0) begin
            miscompares++;
            $display("FAIL rst_mid_ctrl: got m%b w%b wb%b rd%0d busy%b expected all zero",
                     bus.mem_en_out, bus.write_out, bus.en_wb_out, bus.reg_write_out, bus.busy);
        end
        issue(ADD, 32'd7, 32'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
        #1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.result_out !== 32'd15 || bus.en_wb_out !== 1'b1 || bus.reg_write_out !== 5'd6) begin
            miscompares++;
            $display("FAIL rst_then_add: got res %h wb %b rd %0d expected 0000000f 1 6",
                     bus.result_out, bus.en_wb_out, bus.reg_write_out);
        end
        drive_idle();
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.en_wb_out !== 1'b0) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL rst_discard: got %0d stray outputs expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_back_to_back();
        test_bubble_illegal();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/execute.md
# execute

Execute stage of the 5-stage pipeline, directly upstream of the memory stage. It registers an ALU result (effective address or arithmetic result) plus store data and memory/writeback control into the memory stage every cycle. It also contains an iterative 32-cycle unsigned multiplier/divider that stalls the decode stage while it runs.

## Interface
- XLEN, 32, datapath width; only 32 supported
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents a valid instruction
- rs1, rs2  in  XLEN  register operands
- imm  in  XLEN  sign-extended immediate
- use_imm  in  1  operand B = imm (else rs2)
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14–15 illegal
- mem_en, mem_write, load_unsigned, size[1:0], en_wb, use_pcp4, pcp4[XLEN], reg_write[4:0]  in  control forwarded to memory stage
- busy  out  1  combinational stall to decode; inputs must be held stable while high
- result_out  out  XLEN  registered ALU/mul/div result; drives memory addr
- write_data_out  out  XLEN  registered rs2 (store data, never imm)
- mem_en_out, write_out, load_unsigned_out, size_out, en_wb_out, use_pcp4_out, pcp4_out, reg_write_out  out  registered control

## Operation
- Operand B = use_imm ? imm : rs2. Shifts use B[4:0]. SRA is arithmetic. SLT is signed, SLTU unsigned; both yield 0 or 1. ADD/SUB wrap mod 2^32.
- Illegal alu_op: result 0, instruction otherwise passes normally.
- States: IDLE, MUL, DIV; 5-bit iteration counter cnt.
- IDLE, in_valid=1, single-cycle op: all outputs load at next edge with mem_en_out=mem_en, en_wb_out=en_wb.
- IDLE, in_valid=0: mem_en_out=0, en_wb_out=0 at next edge (bubble). Other outputs load from inputs and are don't-care.
- IDLE, in_valid=1, op 10/11:
  - Load A=rs1, B.
  - Clear 64-bit product.
  - Go to MUL with cnt=0.
  - Emit a bubble.
- IDLE, in_valid=1, op 12/13:
  - Load dividend=rs1, divisor=B.
  - Clear remainder.
  - Go to DIV with cnt=0.
  - Emit a bubble.
- MUL: one shift-add step per edge, cnt+1.
- DIV: one restoring step per edge: shift the remainder left by one, bringing in the next dividend bit; subtract the divisor if the remainder ≥ divisor; set the quotient bit.
- Final step (cnt=31): at that edge, state→IDLE and outputs load the result:
  - MUL: product[31:0].
  - MULHU: product[63:32].
  - DIVU: quotient.
  - REMU: remainder.
  - Control: from the held inputs, with mem_en_out/en_wb_out as presented.
- Non-final MUL/DIV edges emit bubbles.
- Divide by zero: no special case; the algorithm yields DIVU=0xFFFFFFFF and REMU=rs1.
- busy = (IDLE & in_valid & op∈{10..13}) | (state≠IDLE & cnt≠31). It drops during the final iteration cycle so decode advances on the completing edge.

## Timing
- Reset (rst_n low, async): all outputs 0, state IDLE, cnt 0, busy 0. Takes effect immediately, including mid-MUL/DIV; the in-flight operation is discarded with no output.
- Single-cycle ops: 1-cycle latency; throughput 1 per cycle.
- MUL/MULHU/DIVU/REMU:
  - Accepted at edge E0, result registered at edge E32.
  - 33 cycles occupied; busy high for 32 cycles.
  - Exactly one valid output per instruction; bubbles during E0..E31.
- Back-to-back mul/div: the next op is presented after E32 and is accepted at E33.
- Inputs changing while busy is a protocol violation; behaviour is undefined.
- Release of rst_n is synchronous to the next clk edge; the first instruction is accepted at the first edge after release.

## Test plan
- Reset: assert rst_n=0 mid-DIV (cnt=10) -> all outputs 0 and busy 0 immediately; next ADD completes normally 1 cycle later.
- ALU: ADD rs1=0x10, imm=0xFFFFFFFC, use_imm=1, mem_en=1, write=1, rs2=0xAB -> result_out=0x0C, write_data_out=0xAB, write_out=1 after 1 edge. SRA 0x80000000 by 4 -> 0xF8000000. SLT 0xFFFFFFFF<1 -> 1; SLTU -> 0.
- MUL: 0xFFFFFFFF × 0xFFFFFFFF -> MUL=0x00000001, MULHU=0xFFFFFFFE. busy high for 32 cycles; exactly one valid output at E32 with reg_write_out as presented.
- DIVU/REMU: 100 / 7 -> 14 and 2. Divide by zero, 0x1234 / 0 -> DIVU=0xFFFFFFFF, REMU=0x1234.
- Pipelining: ADD, MUL, ADD presented back-to-back honoring busy -> valid outputs at cycles 1, 34, 35; no duplicate or lost instruction.
- Bubble/illegal: in_valid=0 -> mem_en_out=0, en_wb_out=0. alu_op=15 with in_valid=1 -> result_out=0 and en_wb_out forwarded.
